// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit datapath.
// Owns the PC, instruction register and zero flag; drives the register file and ALU op.
module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] instr_data,
   input  logic [3:0] alu_result,
   input  logic       alu_zero,
   output logic [3:0] pc,
   output logic [2:0] alu_op,
   output logic [1:0] read_sel1,
   output logic [1:0] read_sel2,
   output logic [1:0] write_sel,
   output logic [3:0] write_data,
   output logic       write_enable,
   output logic       zero_flag,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_MOV  = 4'd6;
   localparam logic [3:0] OP_LDI  = 4'd7;
   localparam logic [3:0] OP_JMP  = 4'd8;
   localparam logic [3:0] OP_BZ   = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;

   state_t     state, state_next;
   logic [7:0] ir;
   logic [3:0] opcode;
   logic       is_alu;
   logic       is_write;
   logic       take_jump;

   assign opcode    = ir[7:4];
   assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_MOV);
   assign is_write  = is_alu || (opcode == OP_LDI);
   assign take_jump = (opcode == OP_JMP) || ((opcode == OP_BZ) && zero_flag);

   // Operand selects come straight from ir, so they are stable from DECODE onward.
   assign read_sel1 = ir[3:2];
   assign read_sel2 = ir[1:0];
   assign write_sel = ir[3:2];

   assign write_enable = (state == S_WRITEBACK);
   assign halted       = (state == S_HALT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= 4'd0;
         ir         <= 8'd0;
         write_data <= 4'd0;
         zero_flag  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_FETCH: begin
               if (run) begin
                  ir <= instr_data;
                  pc <= pc + 4'd1;
               end
            end
            S_EXECUTE: begin
               if (is_alu) begin
                  write_data <= alu_result;
                  zero_flag  <= alu_zero;
               end else if (opcode == OP_LDI) begin
                  write_data <= {2'b00, ir[1:0]};
               end else if (take_jump) begin
                  pc <= ir[3:0];
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:     if (run) state_next = S_DECODE;
         S_DECODE:    state_next = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
         S_EXECUTE:   state_next = is_write ? S_WRITEBACK : S_FETCH;
         S_WRITEBACK: state_next = S_FETCH;
         S_HALT:      state_next = S_HALT;
         default:     state_next = S_FETCH;
      endcase
   end

   // ALU op decodes from ir, which only changes in FETCH, so it holds through EXECUTE.
   always_comb begin
      alu_op = 3'd0;
      case (opcode)
         OP_ADD:  alu_op = 3'd0;
         OP_SUB:  alu_op = 3'd1;
         OP_AND:  alu_op = 3'd2;
         OP_OR:   alu_op = 3'd3;
         OP_XOR:  alu_op = 3'd4;
         OP_MOV:  alu_op = 3'd5;
         default: alu_op = 3'd0;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: models the register file, ALU and instruction memory around the DUT,
// and checks directed scenarios plus random programs against an instruction-level model.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic [7:0] instr_data;
   logic [3:0] alu_result;
   logic       alu_zero;
   logic [3:0] pc;
   logic [2:0] alu_op;
   logic [1:0] read_sel1, read_sel2, write_sel;
   logic [3:0] write_data;
   logic       write_enable, zero_flag, halted;

   int checks = 0;
   int errors = 0;

   control_unit dut (
      .clk(clk), .reset(reset), .run(run), .instr_data(instr_data),
      .alu_result(alu_result), .alu_zero(alu_zero), .pc(pc), .alu_op(alu_op),
      .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
      .write_data(write_data), .write_enable(write_enable), .zero_flag(zero_flag),
      .halted(halted)
   );

   always #5 clk = ~clk;

   // Environment: instruction memory, register file, ALU.
   logic [7:0] imem [16];
   logic [3:0] rf [4];
   logic [5:0] wr_log [$];
   logic       log_clr = 1'b1;

   assign instr_data = imem[pc];

   always @(posedge clk) begin
      if (log_clr) begin
         for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
         wr_log.delete();
      end else if (write_enable) begin
         rf[write_sel] <= write_data;
         wr_log.push_back({write_sel, write_data});
      end
   end

   always_comb begin
      alu_result = 4'd0;
      case (alu_op)
         3'd0: alu_result = rf[read_sel1] + rf[read_sel2];
         3'd1: alu_result = rf[read_sel1] - rf[read_sel2];
         3'd2: alu_result = rf[read_sel1] & rf[read_sel2];
         3'd3: alu_result = rf[read_sel1] | rf[read_sel2];
         3'd4: alu_result = rf[read_sel1] ^ rf[read_sel2];
         3'd5: alu_result = rf[read_sel2];
         default: alu_result = 4'd0;
      endcase
   end
   assign alu_zero = (alu_result == 4'd0);

   // Instruction-level reference model: one call = one whole instruction.
   logic [3:0] m_rf [4];
   logic [3:0] m_pc;
   logic       m_zf, m_halt;
   logic [5:0] exp_log [$];

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
      m_pc = 4'd0; m_zf = 1'b0; m_halt = 1'b0;
      exp_log.delete();
   endtask

   task automatic model_step(output int cyc);
      logic [7:0] ins;
      logic [3:0] a, b, r;
      int op;
      ins = imem[m_pc];
      op  = int'(ins[7:4]);
      a   = m_rf[ins[3:2]];
      b   = m_rf[ins[1:0]];
      m_pc = m_pc + 4'd1;
      cyc = 3;
      r = 4'd0;
      if (op >= 1 && op <= 7) begin
         case (op)
            1: r = a + b;
            2: r = a - b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = b;
            default: r = {2'b00, ins[1:0]};
         endcase
         if (op != 7) m_zf = (r == 4'd0);
         m_rf[ins[3:2]] = r;
         exp_log.push_back({ins[3:2], r});
         cyc = 4;
      end else if (op == 8) begin
         m_pc = ins[3:0];
      end else if (op == 9) begin
         if (m_zf) m_pc = ins[3:0];
      end else if (op == 15) begin
         m_halt = 1'b1;
         cyc = 2;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
   endtask

   task automatic start_test();
      reset = 1'b1; run = 1'b0; log_clr = 1'b1;
      repeat (2) tick();
      log_clr = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_imem();
      start_test();
      if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end checks++;
      if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", write_enable); end checks++;
      if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end checks++;
      if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zf got %0b exp 0", zero_flag); end checks++;
      if ({read_sel1, read_sel2, write_sel, alu_op, write_data} !== 13'd0) begin
         errors++; $display("FAIL reset_outs got %0h exp 0", {read_sel1, read_sel2, write_sel, alu_op, write_data});
      end checks++;
   endtask

   task automatic test_ldi_add();
      clear_imem();
      imem[0] = 8'h76; imem[1] = 8'h15;
      start_test();
      run = 1'b1;
      repeat (5) tick();
      if (alu_op !== 3'd0) begin errors++; $display("FAIL add_alu_op got %0d exp 0", alu_op); end checks++;
      repeat (3) tick();
      if (wr_log.size() !== 2) begin errors++; $display("FAIL ldi_add_count got %0d exp 2", wr_log.size()); end checks++;
      if (wr_log.size() == 2) begin
         if (wr_log[0] !== {2'd1, 4'd2}) begin errors++; $display("FAIL ldi_write got %0h exp %0h", wr_log[0], {2'd1, 4'd2}); end checks++;
         if (wr_log[1] !== {2'd1, 4'd4}) begin errors++; $display("FAIL add_write got %0h exp %0h", wr_log[1], {2'd1, 4'd4}); end checks++;
      end
   endtask

   task automatic test_bz();
      clear_imem();
      imem[0] = 8'h2A; imem[1] = 8'h9C;
      start_test();
      run = 1'b1;
      tick();
      if (alu_op !== 3'd1) begin errors++; $display("FAIL sub_alu_op got %0d exp 1", alu_op); end checks++;
      repeat (2) tick();
      if (write_enable !== 1'b1 || write_data !== 4'd0) begin
         errors++; $display("FAIL sub_wb got we=%0b data=%0d exp we=1 data=0", write_enable, write_data);
      end checks++;
      if (zero_flag !== 1'b1) begin errors++; $display("FAIL sub_zf got %0b exp 1", zero_flag); end checks++;
      repeat (4) tick();
      if (pc !== 4'd12) begin errors++; $display("FAIL bz_taken_pc got %0d exp 12", pc); end checks++;

      clear_imem();
      imem[0] = 8'h75; imem[1] = 8'h15; imem[2] = 8'h9C;
      start_test();
      run = 1'b1;
      repeat (8) tick();
      if (zero_flag !== 1'b0) begin errors++; $display("FAIL add_zf got %0b exp 0", zero_flag); end checks++;
      repeat (3) tick();
      if (pc !== 4'd3) begin errors++; $display("FAIL bz_not_taken_pc got %0d exp 3", pc); end checks++;
   endtask

   task automatic test_jmp_wrap();
      clear_imem();
      imem[3] = 8'h8F;
      start_test();
      run = 1'b1;
      repeat (9) tick();
      if (pc !== 4'd3) begin errors++; $display("FAIL nop_chain_pc got %0d exp 3", pc); end checks++;
      repeat (3) tick();
      if (pc !== 4'd15) begin errors++; $display("FAIL jmp_pc got %0d exp 15", pc); end checks++;
      tick();
      if (pc !== 4'd0) begin errors++; $display("FAIL wrap_pc got %0d exp 0", pc); end checks++;
   endtask

   task automatic test_halt();
      clear_imem();
      imem[0] = 8'hF0;
      start_test();
      run = 1'b1;
      tick();
      if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %0b exp 0", halted); end checks++;
      tick();
      if (halted !== 1'b1) begin errors++; $display("FAIL halt_rise got %0b exp 1", halted); end checks++;
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom_range(0, 1));
         tick();
         if (write_enable !== 1'b0 || pc !== 4'd1 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_hold cycle %0d got we=%0b pc=%0d halted=%0b exp 0/1/1", i, write_enable, pc, halted);
         end checks++;
      end
   endtask

   task automatic test_run_low();
      clear_imem();
      imem[0] = 8'h76;
      start_test();
      repeat (5) tick();
      if (pc !== 4'd0 || read_sel1 !== 2'd0 || write_enable !== 1'b0) begin
         errors++; $display("FAIL run_low got pc=%0d sel1=%0d we=%0b exp 0/0/0", pc, read_sel1, write_enable);
      end checks++;
      run = 1'b1;
      tick();
      if (pc !== 4'd1 || read_sel1 !== 2'd1 || read_sel2 !== 2'd2) begin
         errors++; $display("FAIL run_rise got pc=%0d sel1=%0d sel2=%0d exp 1/1/2", pc, read_sel1, read_sel2);
      end checks++;
   endtask

   task automatic test_reset_mid();
      clear_imem();
      imem[0] = 8'h76; imem[1] = 8'h15;
      start_test();
      run = 1'b1;
      repeat (7) tick();
      if (write_enable !== 1'b1) begin errors++; $display("FAIL mid_wb_we got %0b exp 1", write_enable); end checks++;
      #1 reset = 1'b1;
      #1;
      if (write_enable !== 1'b0 || pc !== 4'd0) begin
         errors++; $display("FAIL mid_reset_async got we=%0b pc=%0d exp 0/0", write_enable, pc);
      end checks++;
      tick();
      if (wr_log.size() !== 1 || rf[1] !== 4'd2) begin
         errors++; $display("FAIL mid_reset_nowrite got count=%0d r1=%0d exp 1/2", wr_log.size(), rf[1]);
      end checks++;
      reset = 1'b0;
      tick();
      if (pc !== 4'd1 || read_sel1 !== 2'd1) begin
         errors++; $display("FAIL mid_restart got pc=%0d sel1=%0d exp 1/1", pc, read_sel1);
      end checks++;
   endtask

   task automatic test_random();
      int c, total;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);
         model_reset();
         total = 0;
         for (int k = 0; k < 14 && !m_halt; k++) begin
            model_step(c);
            total += c;
         end
         start_test();
         run = 1'b1;
         repeat (total) tick();
         if (pc !== m_pc || zero_flag !== m_zf || halted !== m_halt) begin
            errors++; $display("FAIL rand%0d_state got pc=%0d zf=%0b h=%0b exp pc=%0d zf=%0b h=%0b",
                               t, pc, zero_flag, halted, m_pc, m_zf, m_halt);
         end checks++;
         if (wr_log.size() !== exp_log.size()) begin
            errors++; $display("FAIL rand%0d_count got %0d exp %0d", t, wr_log.size(), exp_log.size());
         end checks++;
         for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            if (wr_log[i] !== exp_log[i]) begin
               errors++; $display("FAIL rand%0d_write%0d got %0h exp %0h", t, i, wr_log[i], exp_log[i]);
            end checks++;
         end
         for (int r = 0; r < 4; r++) begin
            if (rf[r] !== m_rf[r]) begin
               errors++; $display("FAIL rand%0d_r%0d got %0d exp %0d", t, r, rf[r], m_rf[r]);
            end checks++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_ldi_add();
      test_bz();
      test_jmp_wrap();
      test_halt();
      test_run_low();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
